// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path: opcodes,
// FSM state encoding, immediate/ALU/write-back select codes, instruction classes.
package multicycle_ctrl_pkg;

   // RV32I major opcodes recognised by the control path
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // addi x0,x0,0 -- IR contents after reset
   localparam logic [31:0] INSTR_NOP = 32'h00000013;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [2:0] IMM_SEL_I = 3'd0;
   localparam logic [2:0] IMM_SEL_S = 3'd1;
   localparam logic [2:0] IMM_SEL_B = 3'd2;
   localparam logic [2:0] IMM_SEL_U = 3'd3;
   localparam logic [2:0] IMM_SEL_J = 3'd4;

   localparam logic [3:0] ALU_OP_ADD    = 4'd0;
   localparam logic [3:0] ALU_OP_SUB    = 4'd1;
   localparam logic [3:0] ALU_OP_SLL    = 4'd2;
   localparam logic [3:0] ALU_OP_SLT    = 4'd3;
   localparam logic [3:0] ALU_OP_SLTU   = 4'd4;
   localparam logic [3:0] ALU_OP_XOR    = 4'd5;
   localparam logic [3:0] ALU_OP_SRL    = 4'd6;
   localparam logic [3:0] ALU_OP_SRA    = 4'd7;
   localparam logic [3:0] ALU_OP_OR     = 4'd8;
   localparam logic [3:0] ALU_OP_AND    = 4'd9;
   localparam logic [3:0] ALU_OP_PASS_B = 4'd10;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   typedef enum logic [3:0] {
      CLS_OP      = 4'd0,
      CLS_OP_IMM  = 4'd1,
      CLS_LUI     = 4'd2,
      CLS_AUIPC   = 4'd3,
      CLS_JAL     = 4'd4,
      CLS_JALR    = 4'd5,
      CLS_BRANCH  = 4'd6,
      CLS_LOAD    = 4'd7,
      CLS_STORE   = 4'd8,
      CLS_SYSTEM  = 4'd9,
      CLS_ILLEGAL = 4'd10
   } instr_class_t;

   // funct3/funct7[5] -> ALU op; SUB only exists in the register form,
   // SRA is selected by funct7[5] in both forms
   function automatic logic [3:0] arith_alu_op(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       is_reg);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = (is_reg && funct7_b5) ? ALU_OP_SUB : ALU_OP_ADD;
         3'b001:  op = ALU_OP_SLL;
         3'b010:  op = ALU_OP_SLT;
         3'b011:  op = ALU_OP_SLTU;
         3'b100:  op = ALU_OP_XOR;
         3'b101:  op = funct7_b5 ? ALU_OP_SRA : ALU_OP_SRL;
         3'b110:  op = ALU_OP_OR;
         default: op = ALU_OP_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decoder: IR -> instruction class, immediate
// format, ALU operation and illegal-opcode flag.
module mc_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [31:0]  ir,
   output instr_class_t cls,
   output logic [2:0]   imm_sel,
   output logic [3:0]   alu_op,
   output logic         illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       unused_ir_bits;

   assign opcode         = ir[6:0];
   assign funct3         = ir[14:12];
   assign funct7_b5      = ir[30];
   assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

   // Classify the major opcode; address and PC arithmetic all use ADD
   always_comb begin
      cls     = CLS_ILLEGAL;
      imm_sel = IMM_SEL_I;
      alu_op  = ALU_OP_ADD;
      illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            cls    = CLS_OP;
            alu_op = arith_alu_op(funct3, funct7_b5, 1'b1);
         end
         OPC_OP_IMM: begin
            cls    = CLS_OP_IMM;
            alu_op = arith_alu_op(funct3, funct7_b5, 1'b0);
         end
         OPC_LUI: begin
            cls     = CLS_LUI;
            imm_sel = IMM_SEL_U;
            alu_op  = ALU_OP_PASS_B;
         end
         OPC_AUIPC: begin
            cls     = CLS_AUIPC;
            imm_sel = IMM_SEL_U;
         end
         OPC_JAL: begin
            cls     = CLS_JAL;
            imm_sel = IMM_SEL_J;
         end
         OPC_JALR:   cls = CLS_JALR;
         OPC_BRANCH: begin
            cls     = CLS_BRANCH;
            imm_sel = IMM_SEL_B;
         end
         OPC_LOAD:   cls = CLS_LOAD;
         OPC_STORE: begin
            cls     = CLS_STORE;
            imm_sel = IMM_SEL_S;
         end
         OPC_SYSTEM: cls = CLS_SYSTEM;
         default:    illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: walks one instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared req/ready memory port and
// drives datapath strobes and selects from (state, ir_q).
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_is_if,
   output logic [31:0] ir_q,
   output logic [2:0]  imm_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [3:0]  alu_op,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        illegal,
   output logic        bus_err,
   output logic        halted
);

   localparam int CW = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t       state;
   logic [CW-1:0] wait_cnt;
   instr_class_t dec_cls;
   logic [3:0]   dec_alu_op;
   logic         dec_illegal;
   logic         waiting;
   logic         timeout_hit;
   logic         dp_active;
   logic         is_jump;

   mc_decode u_decode (
      .ir      (ir_q),
      .cls     (dec_cls),
      .imm_sel (imm_sel),
      .alu_op  (dec_alu_op),
      .illegal (dec_illegal)
   );

   // A stalled request cycle; the final one allowed trips the bus error
   always_comb begin
      waiting     = mem_req && !mem_ready;
      timeout_hit = waiting && (wait_cnt == WAIT_LAST);
   end

   // State, instruction register, wait counter and sticky bus error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RESET;
         ir_q     <= INSTR_NOP;
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         // counter only survives consecutive stalled cycles of one request
         if (waiting && !timeout_hit) wait_cnt <= wait_cnt + CW'(1);
         else                         wait_cnt <= '0;

         case (state)
            ST_RESET: state <= ST_FETCH;
            ST_FETCH: begin
               if (mem_ready) begin
                  ir_q  <= mem_rdata;
                  state <= ST_DECODE;
               end else if (timeout_hit) begin
                  bus_err <= 1'b1;
                  state   <= ST_HALT;
               end
            end
            ST_DECODE: begin
               if (dec_illegal)                state <= ST_FETCH;
               else if (dec_cls == CLS_SYSTEM) state <= ST_HALT;
               else                            state <= ST_EXEC;
            end
            ST_EXEC: begin
               case (dec_cls)
                  CLS_BRANCH:          state <= ST_FETCH;
                  CLS_LOAD, CLS_STORE: state <= ST_MEM;
                  default:             state <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  state <= (dec_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
               end else if (timeout_hit) begin
                  bus_err <= 1'b1;
                  state   <= ST_HALT;
               end
            end
            ST_WB:   state <= ST_FETCH;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_RESET;
         endcase
      end
   end

   // Datapath controls decoded from the current state and latched IR
   always_comb begin
      dp_active = (state == ST_DECODE) || (state == ST_EXEC) ||
                  (state == ST_MEM)    || (state == ST_WB);
      is_jump   = (dec_cls == CLS_JAL) || (dec_cls == CLS_JALR);

      mem_req   = (state == ST_FETCH) || (state == ST_MEM);
      mem_is_if = (state == ST_FETCH);
      mem_we    = (state == ST_MEM) && (dec_cls == CLS_STORE);
      reg_we    = (state == ST_WB);
      illegal   = (state == ST_DECODE) && dec_illegal;
      halted    = (state == ST_HALT);

      pc_we  = 1'b0;
      pc_sel = 1'b0;
      if (state == ST_FETCH) begin
         pc_we = mem_ready;
      end else if (state == ST_EXEC) begin
         if (dec_cls == CLS_BRANCH) begin
            pc_we  = br_taken;
            pc_sel = 1'b1;
         end else if (is_jump) begin
            pc_we  = 1'b1;
            pc_sel = 1'b1;
         end
      end

      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = ALU_OP_ADD;
      wb_sel    = WB_SEL_ALU;
      if (dp_active) begin
         alu_a_sel = (dec_cls == CLS_BRANCH) || (dec_cls == CLS_JAL) ||
                     (dec_cls == CLS_AUIPC);
         alu_b_sel = (dec_cls != CLS_OP);
         alu_op    = dec_alu_op;
         if (dec_cls == CLS_LOAD) wb_sel = WB_SEL_MEM;
         else if (is_jump)        wb_sel = WB_SEL_PC4;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-computed expectations for
// reset, per-class latency, strobes, and the illegal/halt/timeout paths.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        br_taken;
   logic        mem_req;
   logic        mem_we;
   logic        mem_is_if;
   logic [31:0] ir_q;
   logic [2:0]  imm_sel;
   logic        alu_a_sel;
   logic        alu_b_sel;
   logic [3:0]  alu_op;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        pc_we;
   logic        pc_sel;
   logic        illegal;
   logic        bus_err;
   logic        halted;

   int n_vec;
   int n_miss;

   int obs_cycles, obs_we, obs_wb, obs_st, obs_jump, obs_hold, obs_ill, obs_imm;

   multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .br_taken  (br_taken),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_is_if (mem_is_if),
      .ir_q      (ir_q),
      .imm_sel   (imm_sel),
      .alu_a_sel (alu_a_sel),
      .alu_b_sel (alu_b_sel),
      .alu_op    (alu_op),
      .reg_we    (reg_we),
      .wb_sel    (wb_sel),
      .pc_we     (pc_we),
      .pc_sel    (pc_sel),
      .illegal   (illegal),
      .bus_err   (bus_err),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Runs one instruction from FETCH until the FSM is back in FETCH.
   // Instruction fetch is ready in its first cycle; data accesses are
   // ready after data_wait stalled cycles.
   task automatic run_instr(input string name, input logic [31:0] instr,
                            input int data_wait, input logic take);
      int   waited;
      logic done;
      waited = 0; done = 1'b0;
      obs_cycles = 0; obs_we = 0; obs_wb = 0; obs_st = 0;
      obs_jump = 0; obs_hold = 0; obs_ill = 0; obs_imm = 0;
      mem_rdata = instr;
      br_taken  = take;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (c > 0 && mem_req && mem_is_if) begin
            done = 1'b1;
         end else begin
            if (mem_req && !mem_is_if) begin
               mem_ready = (waited == data_wait);
               waited++;
            end else begin
               mem_ready = (c == 0);
            end
            #1;
            obs_cycles++;
            if (c == 1) obs_imm = int'(imm_sel);
            if (reg_we) begin obs_we++; obs_wb = int'(wb_sel); end
            if (mem_we) obs_st++;
            if (pc_we && pc_sel) obs_jump++;
            if (illegal) obs_ill++;
            if (mem_req && !mem_ready) obs_hold++;
            @(negedge clk);
         end
      end
      mem_ready = 1'b0;
      br_taken  = 1'b0;
      check_vec({name, "_back_to_fetch"}, 32'(done), 32'd1);
      $display("txn %-8s ir=%h cycles=%0d reg_we=%0d wb_sel=%0d mem_we=%0d jump=%0d imm=%0d",
               name, instr, obs_cycles, obs_we, obs_wb, obs_st, obs_jump, obs_imm);
   endtask

   initial begin
      n_vec = 0; n_miss = 0;
      rst = 1'b1; mem_rdata = '0; mem_ready = 1'b0; br_taken = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      // RESET state
      check_vec("rst_mem_req", 32'(mem_req), 32'd0);
      check_vec("rst_reg_we",  32'(reg_we),  32'd0);
      check_vec("rst_pc_we",   32'(pc_we),   32'd0);
      check_vec("rst_halted",  32'(halted),  32'd0);
      check_vec("rst_bus_err", 32'(bus_err), 32'd0);
      check_vec("rst_ir_q",    ir_q,         32'h00000013);
      @(negedge clk); #1;
      check_vec("fetch_mem_req",   32'(mem_req),   32'd1);
      check_vec("fetch_mem_is_if", 32'(mem_is_if), 32'd1);

      // addi x1,x0,5 walked cycle by cycle
      mem_rdata = 32'h00500093; mem_ready = 1'b1; #1;
      check_vec("addi_f_pc_we",  32'(pc_we),  32'd1);
      check_vec("addi_f_pc_sel", 32'(pc_sel), 32'd0);
      $display("txn fetch    ir=%h", mem_rdata);
      @(negedge clk); mem_ready = 1'b0; #1;
      check_vec("addi_d_ir_q",      ir_q,             32'h00500093);
      check_vec("addi_d_imm_sel",   32'(imm_sel),     32'd0);
      check_vec("addi_d_alu_b_sel", 32'(alu_b_sel),   32'd1);
      check_vec("addi_d_reg_we",    32'(reg_we),      32'd0);
      @(negedge clk); #1;
      check_vec("addi_e_reg_we", 32'(reg_we), 32'd0);
      check_vec("addi_e_alu_op", 32'(alu_op), 32'd0);
      @(negedge clk); #1;
      check_vec("addi_wb_reg_we", 32'(reg_we), 32'd1);
      check_vec("addi_wb_wb_sel", 32'(wb_sel), 32'd0);
      @(negedge clk); #1;
      check_vec("addi_next_reg_we",  32'(reg_we),    32'd0);
      check_vec("addi_next_fetch",   32'(mem_is_if), 32'd1);

      // lw x2,0(x1) with 3 stalled data cycles
      run_instr("lw_w3", 32'h0000A103, 3, 1'b0);
      check_vec("lw_w3_cycles", obs_cycles, 8);
      check_vec("lw_w3_reg_we", obs_we,     1);
      check_vec("lw_w3_wb_sel", obs_wb,     1);
      check_vec("lw_w3_mem_we", obs_st,     0);
      check_vec("lw_w3_hold",   obs_hold,   3);

      run_instr("lw_w0", 32'h0000A103, 0, 1'b0);
      check_vec("lw_w0_cycles", obs_cycles, 5);

      run_instr("sw", 32'h0020A023, 0, 1'b0);
      check_vec("sw_cycles",  obs_cycles, 4);
      check_vec("sw_mem_we",  obs_st,     1);
      check_vec("sw_reg_we",  obs_we,     0);
      check_vec("sw_imm_sel", obs_imm,    1);

      run_instr("beq_t", 32'h00000463, 0, 1'b1);
      check_vec("beq_t_cycles",  obs_cycles, 3);
      check_vec("beq_t_imm_sel", obs_imm,    2);
      check_vec("beq_t_jump",    obs_jump,   1);
      check_vec("beq_t_reg_we",  obs_we,     0);

      run_instr("beq_nt", 32'h00000463, 0, 1'b0);
      check_vec("beq_nt_cycles", obs_cycles, 3);
      check_vec("beq_nt_jump",   obs_jump,   0);

      run_instr("jal", 32'h008000EF, 0, 1'b0);
      check_vec("jal_cycles",  obs_cycles, 4);
      check_vec("jal_wb_sel",  obs_wb,     2);
      check_vec("jal_jump",    obs_jump,   1);
      check_vec("jal_imm_sel", obs_imm,    4);

      run_instr("lui", 32'h123452B7, 0, 1'b0);
      check_vec("lui_cycles",  obs_cycles, 4);
      check_vec("lui_imm_sel", obs_imm,    3);
      check_vec("lui_reg_we",  obs_we,     1);

      run_instr("illegal", 32'h0000007F, 0, 1'b0);
      check_vec("ill_cycles", obs_cycles, 2);
      check_vec("ill_pulses", obs_ill,    1);
      check_vec("ill_reg_we", obs_we,     0);

      // reset in the middle of a load's MEM phase
      mem_rdata = 32'h0000A103; mem_ready = 1'b1; #1;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check_vec("midmem_req",   32'(mem_req),   32'd1);
      check_vec("midmem_is_if", 32'(mem_is_if), 32'd0);
      check_vec("midmem_we",    32'(mem_we),    32'd0);
      rst = 1'b1; #1;
      check_vec("midrst_mem_req", 32'(mem_req), 32'd0);
      check_vec("midrst_reg_we",  32'(reg_we),  32'd0);
      check_vec("midrst_ir_q",    ir_q,         32'h00000013);
      @(negedge clk); rst = 1'b0; #1;
      check_vec("postrst_mem_req", 32'(mem_req), 32'd0);
      @(negedge clk); #1;
      check_vec("postrst_fetch_req", 32'(mem_req),   32'd1);
      check_vec("postrst_fetch_if",  32'(mem_is_if), 32'd1);
      $display("txn reset mid-MEM");

      // ebreak halts and stops all requests
      mem_rdata = 32'h00100073; mem_ready = 1'b1; #1;
      @(negedge clk); mem_ready = 1'b0; #1;
      check_vec("ebreak_d_halted", 32'(halted), 32'd0);
      @(negedge clk); #1;
      check_vec("ebreak_halted",  32'(halted),  32'd1);
      check_vec("ebreak_mem_req", 32'(mem_req), 32'd0);
      check_vec("ebreak_bus_err", 32'(bus_err), 32'd0);
      begin
         int reqs;
         reqs = 0;
         mem_ready = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (mem_req) reqs++;
         end
         mem_ready = 1'b0;
         check_vec("halt_req_count", reqs, 0);
         check_vec("halt_sticky", 32'(halted), 32'd1);
      end
      $display("txn ebreak");

      // fetch timeout
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;
      check_vec("to_fetch_req", 32'(mem_req), 32'd1);
      repeat (15) @(negedge clk);
      #1;
      check_vec("to_15_bus_err", 32'(bus_err), 32'd0);
      check_vec("to_15_mem_req", 32'(mem_req), 32'd1);
      @(negedge clk); #1;
      check_vec("to_16_bus_err", 32'(bus_err), 32'd1);
      check_vec("to_16_halted",  32'(halted),  32'd1);
      check_vec("to_16_mem_req", 32'(mem_req), 32'd0);
      $display("txn fetch timeout");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
